// File: rtl/mux_pkg.sv
// Shared definitions for the mux_arbiter block.
//   state_t            : arbiter FSM state (IDLE = output empty, VALID = word held)
//   DEFAULT_MUX_WIDTH  : default number of requesters sharing the bus
//   DEFAULT_BUS_WIDTH  : default data word width
package mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam int DEFAULT_MUX_WIDTH = 2;
  localparam int DEFAULT_BUS_WIDTH = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req     : per-requester request bits
//   last    : index of the previous winner
//   winner  : first requesting index found scanning last+1, last+2, ... with wrap
//   any_req : high when at least one request bit is set (winner valid)
module rr_picker #(
  parameter int mux_width = 2
) (
  input  logic [mux_width-1:0]         req,
  input  logic [$clog2(mux_width)-1:0] last,
  output logic [$clog2(mux_width)-1:0] winner,
  output logic                         any_req
);

  localparam int SW = $clog2(mux_width);

  int idx;

  // The scan starts one past the previous winner, so that winner has the
  // lowest priority this time; the modulo handles non-power-of-two widths.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= mux_width; k++) begin
      idx = (int'(last) + k) % mux_width;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter that shares one output register among several requesters.
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   req       : per-requester request bits
//   in        : packed per-requester data words
//   ack       : one-hot (or zero) capture strobe, combinational
//   select    : registered index of the most recently granted requester
//   out_data  : registered captured word
//   out_valid : out_data holds a word not yet consumed
//   out_ready : downstream accepts out_data this cycle
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int mux_width = DEFAULT_MUX_WIDTH,
  parameter int bus_width = DEFAULT_BUS_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [mux_width-1:0]                req,
  input  logic [mux_width-1:0][bus_width-1:0] in,
  output logic [mux_width-1:0]                ack,
  output logic [$clog2(mux_width)-1:0]        select,
  output logic [bus_width-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int SW = $clog2(mux_width);

  state_t        state;
  logic [SW-1:0] last;
  logic [SW-1:0] winner;
  logic          any_req;
  logic          capture;

  rr_picker #(
    .mux_width(mux_width)
  ) u_picker (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any_req(any_req)
  );

  // A word can be taken when the output register is empty or is being
  // drained this cycle; reset gates ack so nothing is acknowledged and lost.
  assign capture = any_req && ((state == IDLE) || out_ready) && !reset;

  always_comb begin
    ack = '0;
    if (capture) ack[winner] = 1'b1;
  end

  // Output register stage: captured word, its source and the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
      select   <= '0;
      last     <= SW'(mux_width - 1);
    end else if (capture) begin
      out_data <= in[winner];
      select   <= winner;
      last     <= winner;
      state    <= VALID;
    end else if ((state == VALID) && out_ready) begin
      state    <= IDLE;
    end
  end

  assign out_valid = (state == VALID);

endmodule
